qeciphy_rx_lock_monitor: RTL and testbench
==========================================

// Module: qeciphy_rx_lock_monitor
// PURPOSE
// Upstream of the link controller: watches the decoded RX frame stream and produces the controller's
// rx_ready, remote_rx_ready and fault_fatal inputs. Declares local frame lock after N consecutive
// training patterns (TPs) and detects remote RX ready from the RDY bit / first data frame.
// Escalates lock timeout or excessive frame errors to a sticky fatal fault.
// PARAMETERS
// LOCK_COUNT    64     consecutive good TPs needed for local lock (>=1)
// REMOTE_COUNT  8      consecutive TPs with RDY=1 needed for remote ready (>=1)
// ERR_WINDOW    1024   error-rate window length, in valid frames
// ERR_LIMIT     4      errors within one window that raise a fault (1..ERR_WINDOW)
// LOCK_TIMEOUT  65536  cycles allowed in SEARCH before a fault
// PORTS
// clk_i              in   1  single clock; all logic on rising edge
// rst_i              in   1  synchronous, active-high reset
// rx_enable_i        in   1  from controller; monitoring active while high
// rx_valid_i         in   1  one decoded frame presented this cycle
// rx_tp_i            in   1  frame is a valid training pattern (qualified by rx_valid_i)
// rx_tp_rdy_i        in   1  RDY bit carried in the TP (qualified by rx_valid_i & rx_tp_i)
// rx_err_i           in   1  frame decode/CRC error (qualified by rx_valid_i)
// rx_ready_o         out  1  local RX frame lock
// remote_rx_ready_o  out  1  remote RX reported locked
// fault_fatal_o      out  1  sticky fatal fault
// fault_code_o       out  2  0 none, 1 lock timeout, 2 error rate, 3 reserved
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; all counters 0. All outputs registered.
// - Good TP = rx_valid_i & rx_tp_i & !rx_err_i. Bad frame = rx_valid_i & (rx_err_i | !rx_tp_i).
// - States: IDLE, SEARCH, LOCKED, FAULT (one-hot).
// - IDLE: rx_enable_i=1 -> SEARCH next cycle; lock, timeout, remote and error counters cleared.
// - SEARCH: good TP -> lock_cnt+1; bad frame -> lock_cnt=0; cycles without valid keep lock_cnt.
//   timeout_cnt increments every cycle; sampled LOCK_COUNT-th consecutive good TP -> LOCKED,
//   rx_ready_o=1 on the next edge (1-cycle latency). timeout_cnt reaching LOCK_TIMEOUT-1 -> FAULT,
//   code 1. Lock and timeout in the same cycle: FAULT wins.
// - LOCKED: rx_ready_o held 1. Remote detection (remote_rx_ready_o sticky while LOCKED):
//   good TP with RDY=1 -> rdy_cnt+1; TP with RDY=0 or any error -> rdy_cnt=0;
//   rdy_cnt reaching REMOTE_COUNT -> remote_rx_ready_o=1 next cycle.
//   Valid error-free non-TP (data) frame -> remote_rx_ready_o=1 next cycle (remote is already
//   sending data).
// - Error rate (LOCKED only): win_cnt counts valid frames, err_cnt counts rx_valid_i & rx_err_i.
//   Window end (win_cnt = ERR_WINDOW-1 and valid): both clear; an error on that last frame
//   is counted before the check. err_cnt reaching ERR_LIMIT -> FAULT, code 2.
//   Error frames never leave LOCKED on their own; there is no relock path.
// - rx_enable_i=0 in SEARCH or LOCKED -> IDLE next cycle; rx_ready_o and remote_rx_ready_o clear
//   with it. A fault in the same cycle wins over the disable.
// - FAULT: fault_fatal_o=1, rx_ready_o=0, remote_rx_ready_o=0, fault_code_o held. Sticky until rst_i.
//   rx_enable_i and frames are ignored.
// - rst_i has priority over everything, in any state and mid-count.
// - Counters are $clog2(param+1) wide and saturate; none wraps.
// TESTING
// - 64 consecutive good TPs (with gaps) -> rx_ready_o=1 exactly 1 cycle after the 64th TP;
//   63 TPs then 1 error -> lock_cnt=0, no lock.
// - Locked; 8 TPs RDY=1 -> remote_rx_ready_o=1; separate run: 7 RDY, 1 RDY=0, 8 RDY -> asserts only
//   after the last 8.
// - Locked; one error-free data frame -> remote_rx_ready_o=1 next cycle.
// - Locked; 4 errors within 1024 frames -> fault_fatal_o=1, code 2.
//   3 errors, window end, 3 more -> no fault.
// - rx_enable_i high, no TPs for 65536 cycles -> fault_fatal_o=1, code 1. Fault stays through
//   rx_enable_i toggling; rst_i clears all outputs.
// - rx_enable_i dropped while LOCKED -> IDLE, all outputs 0 next cycle. Re-enable -> fresh 64-TP lock.

Source files
------------

// File: rtl/qeciphy_rx_lock_monitor.sv
// RX lock monitor: local frame lock from consecutive training patterns, remote-ready
// detection from RDY bits or first data frame, and sticky fatal fault escalation.
module qeciphy_rx_lock_monitor #(
  parameter int LOCK_COUNT   = 64,
  parameter int REMOTE_COUNT = 8,
  parameter int ERR_WINDOW   = 1024,
  parameter int ERR_LIMIT    = 4,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_enable_i,
  input  logic       rx_valid_i,
  input  logic       rx_tp_i,
  input  logic       rx_tp_rdy_i,
  input  logic       rx_err_i,
  output logic       rx_ready_o,
  output logic       remote_rx_ready_o,
  output logic       fault_fatal_o,
  output logic [1:0] fault_code_o
);

  localparam int LCW = $clog2(LOCK_COUNT + 1);
  localparam int RCW = $clog2(REMOTE_COUNT + 1);
  localparam int WCW = $clog2(ERR_WINDOW + 1);
  localparam int ECW = $clog2(ERR_LIMIT + 1);
  localparam int TCW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_COUNT - 1);
  localparam logic [LCW-1:0] LOCK_MAX  = LCW'(LOCK_COUNT);
  localparam logic [RCW-1:0] RDY_LAST  = RCW'(REMOTE_COUNT - 1);
  localparam logic [RCW-1:0] RDY_MAX   = RCW'(REMOTE_COUNT);
  localparam logic [WCW-1:0] WIN_LAST  = WCW'(ERR_WINDOW - 1);
  localparam logic [ECW-1:0] ERR_LAST  = ECW'(ERR_LIMIT - 1);
  localparam logic [ECW-1:0] ERR_MAX   = ECW'(ERR_LIMIT);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(LOCK_TIMEOUT - 1);
  localparam logic [TCW-1:0] TMO_MAX   = TCW'(LOCK_TIMEOUT);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_SEARCH = 4'b0010,
    ST_LOCKED = 4'b0100,
    ST_FAULT  = 4'b1000
  } state_t;

  state_t         state_r;
  logic [LCW-1:0] lock_cnt_r;
  logic [RCW-1:0] rdy_cnt_r;
  logic [WCW-1:0] win_cnt_r;
  logic [ECW-1:0] err_cnt_r;
  logic [TCW-1:0] timeout_cnt_r;
  logic           rx_ready_r;
  logic           remote_r;
  logic           fault_fatal_r;
  logic [1:0]     fault_code_r;

  logic good_tp_s;
  logic bad_frame_s;
  logic err_frame_s;
  logic err_hit_s;

  // Frame classification; err_hit_s counts an error on the current frame before the limit check.
  always_comb begin
    good_tp_s   = rx_valid_i & rx_tp_i & ~rx_err_i;
    bad_frame_s = rx_valid_i & (rx_err_i | ~rx_tp_i);
    err_frame_s = rx_valid_i & rx_err_i;
    err_hit_s   = err_frame_s & (err_cnt_r >= ERR_LAST);
  end

  // Monitor state machine with registered outputs; FAULT is left only through rst_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= ST_IDLE;
      lock_cnt_r    <= '0;
      rdy_cnt_r     <= '0;
      win_cnt_r     <= '0;
      err_cnt_r     <= '0;
      timeout_cnt_r <= '0;
      rx_ready_r    <= 1'b0;
      remote_r      <= 1'b0;
      fault_fatal_r <= 1'b0;
      fault_code_r  <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          lock_cnt_r    <= '0;
          rdy_cnt_r     <= '0;
          win_cnt_r     <= '0;
          err_cnt_r     <= '0;
          timeout_cnt_r <= '0;
          rx_ready_r    <= 1'b0;
          remote_r      <= 1'b0;
          if (rx_enable_i) begin
            state_r <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (timeout_cnt_r == TMO_LAST) begin
            state_r       <= ST_FAULT;
            fault_fatal_r <= 1'b1;
            fault_code_r  <= 2'd1;
          end else if (!rx_enable_i) begin
            state_r <= ST_IDLE;
          end else if (good_tp_s && (lock_cnt_r == LOCK_LAST)) begin
            state_r    <= ST_LOCKED;
            rx_ready_r <= 1'b1;
          end
          if (timeout_cnt_r != TMO_MAX) begin
            timeout_cnt_r <= timeout_cnt_r + TCW'(1);
          end
          if (good_tp_s) begin
            if (lock_cnt_r != LOCK_MAX) begin
              lock_cnt_r <= lock_cnt_r + LCW'(1);
            end
          end else if (bad_frame_s) begin
            lock_cnt_r <= '0;
          end
        end
        ST_LOCKED: begin
          if (err_hit_s) begin
            state_r       <= ST_FAULT;
            fault_fatal_r <= 1'b1;
            fault_code_r  <= 2'd2;
            rx_ready_r    <= 1'b0;
            remote_r      <= 1'b0;
          end else if (!rx_enable_i) begin
            state_r    <= ST_IDLE;
            rx_ready_r <= 1'b0;
            remote_r   <= 1'b0;
          end else if ((good_tp_s && rx_tp_rdy_i && (rdy_cnt_r >= RDY_LAST)) ||
                       (rx_valid_i && !rx_tp_i && !rx_err_i)) begin
            // A clean data frame means the remote end is already past training.
            remote_r <= 1'b1;
          end
          if (good_tp_s && rx_tp_rdy_i) begin
            if (rdy_cnt_r != RDY_MAX) begin
              rdy_cnt_r <= rdy_cnt_r + RCW'(1);
            end
          end else if (rx_valid_i && (rx_err_i || rx_tp_i)) begin
            rdy_cnt_r <= '0;
          end
          if (rx_valid_i) begin
            if (win_cnt_r == WIN_LAST) begin
              win_cnt_r <= '0;
              err_cnt_r <= '0;
            end else begin
              win_cnt_r <= win_cnt_r + WCW'(1);
              if (err_frame_s && (err_cnt_r != ERR_MAX)) begin
                err_cnt_r <= err_cnt_r + ECW'(1);
              end
            end
          end
        end
        ST_FAULT: begin
          rx_ready_r    <= 1'b0;
          remote_r      <= 1'b0;
          fault_fatal_r <= 1'b1;
        end
        default: begin
          state_r    <= ST_IDLE;
          rx_ready_r <= 1'b0;
          remote_r   <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready_o        = rx_ready_r;
  assign remote_rx_ready_o = remote_r;
  assign fault_fatal_o     = fault_fatal_r;
  assign fault_code_o      = fault_code_r;

endmodule

// File: tb/tb_qeciphy_rx_lock_monitor.sv
// Self-checking bench for qeciphy_rx_lock_monitor: directed scenarios plus randomized
// episodes, all compared every cycle against a frame-history reference model.
module tb_qeciphy_rx_lock_monitor;

  localparam int LOCK_COUNT   = 64;
  localparam int REMOTE_COUNT = 8;
  localparam int ERR_WINDOW   = 1024;
  localparam int ERR_LIMIT    = 4;
  localparam int LOCK_TIMEOUT = 65536;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       v   = 1'b0;
  logic       tp  = 1'b0;
  logic       rdy = 1'b0;
  logic       err = 1'b0;
  logic       rx_ready;
  logic       remote;
  logic       fatal;
  logic [1:0] code;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model: what the outputs must be given the frame history so far.
  bit m_search;
  bit m_locked;
  bit m_remote;
  int m_code;
  int m_run;
  int m_cyc;
  int m_rdy;
  int m_frames;
  int m_errs;

  always #5 clk = ~clk;

  qeciphy_rx_lock_monitor #(
    .LOCK_COUNT  (LOCK_COUNT),
    .REMOTE_COUNT(REMOTE_COUNT),
    .ERR_WINDOW  (ERR_WINDOW),
    .ERR_LIMIT   (ERR_LIMIT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .rx_enable_i      (en),
    .rx_valid_i       (v),
    .rx_tp_i          (tp),
    .rx_tp_rdy_i      (rdy),
    .rx_err_i         (err),
    .rx_ready_o       (rx_ready),
    .remote_rx_ready_o(remote),
    .fault_fatal_o    (fatal),
    .fault_code_o     (code)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_search = 1'b0; m_locked = 1'b0; m_remote = 1'b0;
    m_run = 0; m_cyc = 0; m_rdy = 0; m_frames = 0; m_errs = 0;
  endtask

  task automatic model_step();
    bit good;
    if (rst) begin
      model_clear();
      m_code = 0;
      return;
    end
    if (m_code != 0) return;
    good = v && tp && !err;
    if (m_locked) begin
      if (v) begin
        m_frames++;
        if (err) m_errs++;
      end
      if (m_errs >= ERR_LIMIT) begin
        m_code = 2;
        model_clear();
        return;
      end
      if (v && m_frames == ERR_WINDOW) begin
        m_frames = 0;
        m_errs = 0;
      end
      if (!en) begin
        model_clear();
        return;
      end
      if (good && rdy) m_rdy++;
      else if (v && (err || tp)) m_rdy = 0;
      if (m_rdy >= REMOTE_COUNT || (v && !tp && !err)) m_remote = 1'b1;
    end else if (m_search) begin
      m_cyc++;
      if (m_cyc >= LOCK_TIMEOUT) begin
        m_code = 1;
        model_clear();
        return;
      end
      if (!en) begin
        model_clear();
        return;
      end
      if (good) m_run++;
      else if (v) m_run = 0;
      if (m_run >= LOCK_COUNT) begin
        m_search = 1'b0;
        m_locked = 1'b1;
      end
    end else if (en) begin
      model_clear();
      m_search = 1'b1;
    end
  endtask

  initial begin
    model_clear();
    m_code = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("rx_ready_o", rx_ready, m_locked);
        chk("remote_rx_ready_o", remote, m_remote);
        chk("fault_fatal_o", fatal, m_code != 0);
        chk("fault_code_o", code, m_code[1:0]);
      end
    end
  end

  task automatic frame(input bit fv, input bit ftp, input bit frdy, input bit ferr);
    @(negedge clk);
    v = fv; tp = ftp; rdy = frdy; err = ferr;
  endtask

  task automatic send_tps(input int n, input bit r);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) frame(1'b0, 1'b0, 1'b0, 1'b0);
      frame(1'b1, 1'b1, r, 1'b0);
    end
  endtask

  task automatic relock(input string name);
    en = 1'b0;
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    send_tps(LOCK_COUNT, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk(name, rx_ready, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0;
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_outputs", {rx_ready, remote, fatal, code}, 5'b0);
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fv, ftp, frdy, ferr;
    int errp;
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    cmp_en = 1'b1;
    do_reset();

    // Lock: 63 TPs then an error restarts the count; then 64 TPs lock one cycle later.
    en = 1'b1;
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    send_tps(LOCK_COUNT - 1, 1'b0);
    frame(1'b1, 1'b1, 1'b0, 1'b1);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("no_lock_after_63_and_err", rx_ready, 1'b0);
    send_tps(LOCK_COUNT, 1'b0);
    chk("no_lock_before_64th_sampled", rx_ready, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("lock_after_64", rx_ready, 1'b1);
    chk("remote_low_after_lock", remote, 1'b0);

    // Remote ready from 8 consecutive RDY TPs.
    send_tps(REMOTE_COUNT, 1'b1);
    chk("remote_low_before_8th", remote, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("remote_after_8_rdy", remote, 1'b1);

    // Disable while locked: all outputs drop next cycle.
    en = 1'b0;
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("disable_outputs", {rx_ready, remote, fatal, code}, 5'b0);

    // 7 RDY, one RDY=0, 8 RDY: asserts only after the final 8.
    relock("relock_a");
    send_tps(REMOTE_COUNT - 1, 1'b1);
    frame(1'b1, 1'b1, 1'b0, 1'b0);
    send_tps(REMOTE_COUNT, 1'b1);
    chk("remote_low_after_7_1_7", remote, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("remote_after_final_8", remote, 1'b1);

    // A clean data frame marks remote ready on the next edge.
    relock("relock_b");
    frame(1'b1, 1'b0, 1'b0, 1'b0);
    chk("remote_low_data_unsampled", remote, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("remote_after_data", remote, 1'b1);

    // Error rate: 3 errors, window end, 3 more (no fault), then a 4th in that window.
    relock("relock_c");
    repeat (3) frame(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (ERR_WINDOW - 3) frame(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) frame(1'b1, 1'b1, 1'b0, 1'b1);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("no_fault_3_per_window", fatal, 1'b0);
    chk("still_locked_with_errors", rx_ready, 1'b1);
    frame(1'b1, 1'b1, 1'b0, 1'b1);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("err_rate_fault", fatal, 1'b1);
    chk("err_rate_code", code, 2'd2);
    chk("err_rate_ready_low", rx_ready, 1'b0);
    for (int i = 0; i < 10; i++) begin
      en = i[0];
      frame(1'b1, 1'b1, 1'b1, 1'b0);
    end
    chk("err_fault_sticky", {fatal, code}, 3'b110);
    do_reset();

    // Lock timeout: enabled with no TPs.
    en = 1'b1;
    repeat (LOCK_TIMEOUT) frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("no_fault_before_timeout", fatal, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("timeout_fault", fatal, 1'b1);
    chk("timeout_code", code, 2'd1);
    for (int i = 0; i < 8; i++) begin
      en = ~en;
      frame(1'b1, 1'b1, 1'b1, 1'b0);
    end
    chk("timeout_sticky", {rx_ready, remote, fatal, code}, 5'b00101);
    do_reset();

    // Randomized episodes, including resets and disables mid-count.
    for (int ep = 0; ep < 6; ep++) begin
      errp = ep[0] ? 600 : 150;
      en = 1'b1;
      for (int c = 0; c < 1500; c++) begin
        en   = ($urandom_range(0, 299) != 0);
        rst  = ($urandom_range(0, 999) == 0);
        fv   = ($urandom_range(0, 9) < 7);
        ftp  = ($urandom_range(0, 199) != 0);
        frdy = ($urandom_range(0, 9) < 7);
        ferr = ($urandom_range(0, errp) == 0);
        frame(fv, ftp, frdy, ferr);
      end
      rst = 1'b0;
      do_reset();
    end

    frame(1'b0, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
